// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the pipeline hazard/stall controller: register width,
// memory opcodes, FSM state encodings and the saturating counter helper.
package hazard_stall_unit_pkg;

  localparam int          RSIZE_DEF = 5;
  localparam logic [3:0]  OP_LW_DEF = 4'd8;
  localparam logic [3:0]  OP_SW_DEF = 4'd9;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERR      = 2'd2
  } state_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard controller: load-use bubbles, branch flushes, data-memory
// freeze with timeout, plus saturating stall/flush performance counters.
//
//   state       | meaning
//   ------------+------------------------------------------------------------
//   ST_RUN      | normal flow; a memory wait freezes and enters ST_MEM_WAIT
//   ST_MEM_WAIT | frozen on data memory; counts waited cycles up to TIMEOUT
//   ST_ERR      | one-cycle timeout exit; freeze released, MEM_Timeout set
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int          RSIZE   = RSIZE_DEF,
  parameter logic [3:0]  OP_LW   = OP_LW_DEF,
  parameter logic [3:0]  OP_SW   = OP_SW_DEF,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [RSIZE-1:0] ID_RAddr1,
  input  logic [RSIZE-1:0] ID_RAddr2,
  input  logic [RSIZE-1:0] EX_WAddr,
  input  logic             EX_RFWen,
  input  logic [3:0]       EX_opCode,
  input  logic             EX_BrTaken,
  input  logic [3:0]       MEM_opCode,
  input  logic             DMEM_Ready,
  output logic             PC_Stall,
  output logic             IF_ID_Stall,
  output logic             ID_EX_Bubble,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             Pipe_Freeze,
  output logic             MEM_Timeout,
  output logic [15:0]      Stall_Cnt,
  output logic [15:0]      Flush_Cnt
);

  state_e      r_state;
  logic [7:0]  r_wait_cnt;
  logic        r_lu_done;
  logic        r_mem_timeout;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic        w_load_use;
  logic        w_mem_wait;
  logic        w_freeze;
  logic        w_flush;
  logic        w_bubble;
  logic [8:0]  w_wait_nxt;

  // Outputs are gated by rst_n so nothing leaks out while reset is held.
  always_comb begin
    w_load_use = (EX_opCode == OP_LW) && EX_RFWen && (EX_WAddr != '0) &&
                 ((EX_WAddr == ID_RAddr1) || (EX_WAddr == ID_RAddr2));
    w_mem_wait = ((MEM_opCode == OP_LW) || (MEM_opCode == OP_SW)) && !DMEM_Ready;
    w_freeze   = rst_n && w_mem_wait && (r_state != ST_ERR);
    w_flush    = rst_n && !w_freeze && EX_BrTaken;
    w_bubble   = rst_n && !w_freeze && !w_flush && w_load_use && !r_lu_done;
    w_wait_nxt = {1'b0, r_wait_cnt} + 9'd1;
  end

  assign Pipe_Freeze  = w_freeze;
  assign PC_Stall     = w_freeze | w_bubble;
  assign IF_ID_Stall  = w_freeze | w_bubble;
  assign ID_EX_Bubble = w_bubble;
  assign IF_ID_Flush  = w_flush;
  assign ID_EX_Flush  = w_flush;
  assign MEM_Timeout  = r_mem_timeout;
  assign Stall_Cnt    = r_stall_cnt;
  assign Flush_Cnt    = r_flush_cnt;

  // wait_cnt holds cycles already waited; ERR is entered once that reaches TIMEOUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= 8'd0;
      r_mem_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_wait) begin
            r_wait_cnt <= 8'd1;
            if (TIMEOUT <= 8'd1) begin
              r_state       <= ST_ERR;
              r_mem_timeout <= 1'b1;
            end else begin
              r_state <= ST_MEM_WAIT;
            end
          end
        end
        ST_MEM_WAIT: begin
          if (!w_mem_wait) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
          end else if (w_wait_nxt >= {1'b0, TIMEOUT}) begin
            r_state       <= ST_ERR;
            r_wait_cnt    <= w_wait_nxt[7:0];
            r_mem_timeout <= 1'b1;
          end else begin
            r_wait_cnt <= w_wait_nxt[7:0];
          end
        end
        ST_ERR: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= 8'd0;
        end
        default: begin
          r_state    <= ST_RUN;
          r_wait_cnt <= 8'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lu_done <= 1'b0;
    end else if (!w_load_use) begin
      r_lu_done <= 1'b0;
    end else if (w_bubble) begin
      r_lu_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (PC_Stall)    r_stall_cnt <= sat_inc16(r_stall_cnt);
      if (ID_EX_Flush) r_flush_cnt <= sat_inc16(r_flush_cnt);
    end
  end

endmodule
